sample_capture: RTL and testbench

SAMPLE_CAPTURE -- requirements
Module: sample_capture

---
 rtl/sample_capture_if.sv | 23 ++
 rtl/sample_capture.sv | 167 ++++++++++++++++
 tb/tb_sample_capture.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sample_capture_if.sv
// Bundle of the signals around sample_capture: the start strobe and timestamp, the register-bus
// read port the block drives, and the snapshot read port.
interface sample_capture_if;
    logic        sample_start;
    logic [31:0] timestamp;
    logic [15:0] reg_raddr;
    logic [31:0] reg_rdata;
    logic        sample_busy;
    logic [3:0]  sample_chan;
    logic [5:0]  sample_raddr;
    logic [31:0] sample_rdata;

    // master: the capture block, which owns the register-bus read address
    modport master (
        input  sample_start, timestamp, reg_rdata, sample_raddr,
        output reg_raddr, sample_busy, sample_chan, sample_rdata
    );

    modport slave (
        output sample_start, timestamp, reg_rdata, sample_raddr,
        input  reg_raddr, sample_busy, sample_chan, sample_rdata
    );
endinterface

// File: rtl/sample_capture.sv
// Takes a coherent snapshot of motor/encoder registers over a 2-cycle-latency read bus into a
// back bank, then swaps banks so the snapshot port always returns a complete capture.
module sample_capture #(
    parameter int NUM_MOTORS   = 8,
    parameter int NUM_ENCODERS = 8
) (
    input  logic             sysclk,
    input  logic             reset,
    sample_capture_if.master bus
);
    localparam int NUM_QUADS = 4 + 2 * NUM_MOTORS + 5 * NUM_ENCODERS;
    localparam int QW        = $clog2(NUM_QUADS);
    localparam logic [QW-1:0] LAST_IDX = QW'(NUM_QUADS - 1);
    localparam logic [31:0]   NQ_U     = 32'(NUM_QUADS);

    // {chan, dev} fetched into snapshot quadlet q
    function automatic logic [7:0] quad_addr(input int q);
        int         r;
        logic [3:0] chan;
        logic [3:0] dev;
        chan = 4'h0;
        dev  = 4'h0;
        r    = 0;
        if (q == 2) begin
            dev = 4'hA;
        end else if (q == 3) begin
            dev = 4'h3;
        end else if (q >= 4 && q < 4 + NUM_MOTORS) begin
            chan = 4'(q - 3);
        end else if (q >= 4 + NUM_MOTORS && q < 4 + 2 * NUM_MOTORS) begin
            chan = 4'(q - 3 - NUM_MOTORS);
            dev  = 4'hC;
        end else if (q >= 4 + 2 * NUM_MOTORS) begin
            r    = q - 4 - 2 * NUM_MOTORS;
            chan = 4'(r % NUM_ENCODERS + 1);
            dev  = 4'(5 + r / NUM_ENCODERS);
        end
        return {chan, dev};
    endfunction

    logic [7:0] addr_rom [NUM_QUADS];

    generate
        for (genvar gi = 0; gi < NUM_QUADS; gi++) begin : g_rom
            assign addr_rom[gi] = quad_addr(gi);
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t        state_reg;
    logic          busy_reg;
    logic [7:0]    addr_reg;
    logic [QW-1:0] idx_reg;
    logic [QW-1:0] idx_next;
    logic          drain_reg;
    logic          bank_reg;
    logic          valid_reg;
    logic          p1_valid_reg;
    logic          p2_valid_reg;
    logic [QW-1:0] p1_idx_reg;
    logic [QW-1:0] p2_idx_reg;
    logic [31:0]   rdata_reg;

    assign idx_next = idx_reg + 1'b1;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            addr_reg     <= 8'h00;
            idx_reg      <= '0;
            drain_reg    <= 1'b0;
            bank_reg     <= 1'b0;
            valid_reg    <= 1'b0;
            p1_valid_reg <= 1'b0;
            p2_valid_reg <= 1'b0;
            p1_idx_reg   <= '0;
            p2_idx_reg   <= '0;
        end else begin
            // Tracks each issued address until its data arrives two cycles later
            p1_valid_reg <= (state_reg == ISSUE);
            p1_idx_reg   <= idx_reg;
            p2_valid_reg <= p1_valid_reg;
            p2_idx_reg   <= p1_idx_reg;
            case (state_reg)
                IDLE: begin
                    if (bus.sample_start) begin
                        state_reg <= ISSUE;
                        busy_reg  <= 1'b1;
                        idx_reg   <= QW'(1);
                        addr_reg  <= addr_rom[1];
                    end
                end
                ISSUE: begin
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= DRAIN;
                        addr_reg  <= 8'h00;
                        drain_reg <= 1'b0;
                    end else begin
                        idx_reg  <= idx_next;
                        addr_reg <= addr_rom[idx_next];
                    end
                end
                DRAIN: begin
                    if (drain_reg) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        bank_reg  <= ~bank_reg;
                        valid_reg <= 1'b1;
                    end else begin
                        drain_reg <= 1'b1;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Single write port: the timestamp on the start edge, returned bus data otherwise
    logic          wr_en;
    logic [QW-1:0] wr_idx;
    logic [31:0]   wr_data;

    always_comb begin
        wr_en   = p2_valid_reg;
        wr_idx  = p2_idx_reg;
        wr_data = bus.reg_rdata;
        if (state_reg == IDLE && bus.sample_start) begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            wr_data = bus.timestamp;
        end
    end

    logic          rd_in_range;
    logic [QW-1:0] rd_idx;
    logic [31:0]   rd_word [2];

    assign rd_in_range = ({26'd0, bus.sample_raddr} < NQ_U);
    assign rd_idx      = rd_in_range ? QW'(bus.sample_raddr) : '0;

    // Bank gi is the back bank whenever bank_reg points at the other one
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            logic [31:0] mem [NUM_QUADS];
            always_ff @(posedge sysclk) begin
                if (wr_en && (bank_reg != 1'(gi)))
                    mem[wr_idx] <= wr_data;
            end
            assign rd_word[gi] = mem[rd_idx];
        end
    endgenerate

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset)
            rdata_reg <= 32'h0;
        else
            rdata_reg <= (valid_reg && rd_in_range) ? rd_word[bank_reg] : 32'h0;
    end

    assign bus.reg_raddr    = {8'h00, addr_reg};
    assign bus.sample_chan  = addr_reg[7:4];
    assign bus.sample_busy  = busy_reg;
    assign bus.sample_rdata = rdata_reg;
endmodule

// File: tb/tb_sample_capture.sv
// Bench for sample_capture: a register-bus responder, a snapshot-level reference model checked
// every cycle, and directed captures with hand-computed literal expectations.
module tb_sample_capture;
    localparam int NQ = 60;

    logic        sysclk = 1'b0;
    logic        reset;
    logic [15:0] tag;
    logic [15:0] d1, d2;
    int          vectors = 0;
    int          miscompares = 0;
    logic        chk_en = 1'b0;

    always #5 sysclk = ~sysclk;

    sample_capture_if bus();

    sample_capture #(.NUM_MOTORS(8), .NUM_ENCODERS(8)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    // Register bus: returns {tag, address} two cycles after the address is presented
    always @(posedge sysclk) begin
        d1 <= bus.reg_raddr;
        d2 <= d1;
    end
    assign bus.reg_rdata = {tag, d2};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Snapshot layout as a list of register addresses, in quadlet order
    logic [15:0] addr_list [64];
    initial begin
        int n;
        for (int i = 0; i < 64; i++) addr_list[i] = 16'h0;
        n = 1;
        addr_list[n] = 16'h0000; n++;
        addr_list[n] = 16'h000A; n++;
        addr_list[n] = 16'h0003; n++;
        for (int m = 0; m < 8; m++) begin addr_list[n] = {8'h00, 4'(m + 1), 4'h0}; n++; end
        for (int m = 0; m < 8; m++) begin addr_list[n] = {8'h00, 4'(m + 1), 4'hC}; n++; end
        for (int d = 5; d <= 9; d++)
            for (int e = 0; e < 8; e++) begin addr_list[n] = {8'h00, 4'(e + 1), 4'(d)}; n++; end
    end

    // Reference model: age counts edges since the accepted start
    logic [31:0] m_front [64];
    logic [31:0] m_back  [64];
    logic        m_active, m_valid;
    int          m_age;
    logic        exp_busy;
    logic [31:0] exp_rdata;
    logic [15:0] exp_addr;
    logic        exp_addr_chk;

    always @(posedge sysclk or posedge reset) begin
        if (reset) begin
            m_active     = 1'b0;
            m_valid      = 1'b0;
            m_age        = 0;
            exp_busy     = 1'b0;
            exp_rdata    = 32'h0;
            exp_addr     = 16'h0;
            exp_addr_chk = 1'b1;
        end else begin
            exp_rdata = (m_valid && bus.sample_raddr < 6'(NQ)) ? m_front[bus.sample_raddr] : 32'h0;
            if (!m_active) begin
                if (bus.sample_start) begin
                    m_active  = 1'b1;
                    m_age     = 0;
                    m_back[0] = bus.timestamp;
                    for (int j = 1; j < NQ; j++) m_back[j] = {tag, addr_list[j]};
                end
            end else begin
                m_age++;
                if (m_age == NQ + 1) begin
                    for (int j = 0; j < NQ; j++) m_front[j] = m_back[j];
                    m_valid = 1'b1;
                end
                if (m_age == NQ + 2) m_active = 1'b0;
            end
            exp_busy = m_active && (m_age <= NQ);
            if (exp_busy && m_age <= NQ - 2) begin
                exp_addr     = addr_list[m_age + 1];
                exp_addr_chk = 1'b1;
            end else if (!exp_busy) begin
                exp_addr     = 16'h0;
                exp_addr_chk = 1'b1;
            end else begin
                exp_addr_chk = 1'b0;
            end
        end
    end

    always @(negedge sysclk) begin
        if (chk_en) begin
            check("busy", {31'd0, bus.sample_busy}, {31'd0, exp_busy});
            check("sample_rdata", bus.sample_rdata, exp_rdata);
            if (exp_addr_chk) begin
                check("reg_raddr", {16'd0, bus.reg_raddr}, {16'd0, exp_addr});
                check("sample_chan", {28'd0, bus.sample_chan}, {28'd0, exp_addr[7:4]});
            end
        end
    end

    task automatic read_chk(input int a, input logic [31:0] exp, input string nm);
        @(negedge sysclk);
        #1 bus.sample_raddr = 6'(a);
        @(posedge sysclk);
        @(negedge sysclk);
        check(nm, bus.sample_rdata, exp);
        $display("read q%0d -> %h (expect %h)", a, bus.sample_rdata, exp);
    endtask

    task automatic capture(input logic [31:0] ts, input logic [15:0] tg, input string nm);
        int cnt;
        @(negedge sysclk);
        #1;
        tag              = tg;
        bus.timestamp    = ts;
        bus.sample_start = 1'b1;
        @(posedge sysclk);
        #1 bus.sample_start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sysclk);
            if (bus.sample_busy) cnt++;
            else break;
        end
        check(nm, 32'(cnt), 32'd61);
        $display("capture ts=%h tag=%h busy for %0d cycles", ts, tg, cnt);
    endtask

    initial begin
        int cnt;
        reset            = 1'b1;
        tag              = 16'h0;
        bus.sample_start = 1'b0;
        bus.timestamp    = 32'h0;
        bus.sample_raddr = 6'd0;
        repeat (3) @(posedge sysclk);
        chk_en = 1'b1;
        @(negedge sysclk);
        #1 reset = 1'b0;

        // Nothing published yet
        for (int a = 0; a < NQ; a++) read_chk(a, 32'h0, "pre_capture_read");

        capture(32'h12345678, 16'hA5A5, "busy_cycles_1");
        read_chk(0,  32'h12345678, "cap1_q0");
        read_chk(1,  32'hA5A50000, "cap1_q1");
        read_chk(2,  32'hA5A5000A, "cap1_q2");
        read_chk(4,  32'hA5A50010, "cap1_q4");
        read_chk(59, 32'hA5A50089, "cap1_q59");

        // Second capture with extra start pulses while reading q5 every cycle
        tag           = 16'h5A5A;
        bus.timestamp = 32'hCAFEF00D;
        cnt = 0;
        @(negedge sysclk);
        for (int k = 0; k <= 70; k++) begin
            #1;
            bus.sample_start = (k == 0 || k == 10 || k == 61);
            bus.sample_raddr = 6'd5;
            @(posedge sysclk);
            @(negedge sysclk);
            if (bus.sample_busy) cnt++;
            if (k == 30) check("cap2_q5_old", bus.sample_rdata, 32'hA5A50020);
            if (k == 66) check("cap2_q5_new", bus.sample_rdata, 32'h5A5A0020);
        end
        check("busy_cycles_2", 32'(cnt), 32'd61);
        $display("capture 2 with ignored restarts: busy for %0d cycles", cnt);

        // Third capture abandoned by reset at N+30
        tag           = 16'h1111;
        bus.timestamp = 32'h0BADBEEF;
        @(negedge sysclk);
        for (int k = 0; k <= 30; k++) begin
            #1 bus.sample_start = (k == 0);
            @(posedge sysclk);
            @(negedge sysclk);
        end
        #1 reset = 1'b1;
        #1;
        check("reset_busy", {31'd0, bus.sample_busy}, 32'd0);
        check("reset_rdata", bus.sample_rdata, 32'h0);
        check("reset_raddr", {16'd0, bus.reg_raddr}, 32'h0);
        $display("reset during capture: busy=%b rdata=%h", bus.sample_busy, bus.sample_rdata);
        @(negedge sysclk);
        #1 reset = 1'b0;
        read_chk(5, 32'h0, "after_reset_q5");

        capture(32'hDEADBEEF, 16'h2222, "busy_cycles_4");
        read_chk(0,  32'hDEADBEEF, "cap4_q0");
        read_chk(3,  32'h22220003, "cap4_q3");
        read_chk(5,  32'h22220020, "cap4_q5");
        read_chk(59, 32'h22220089, "cap4_q59");
        for (int a = 60; a < 64; a++) read_chk(a, 32'h0, "out_of_range");

        repeat (2) @(negedge sysclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
